// File: rtl/flt_pack.sv
// flt_pack: serializes a filtered-scanline word stream into a zlib-payload byte stream,
//   optionally followed by the big-endian Adler-32 trailer of the emitted bytes.
// Latency: combinational FIFO-head -> byte path; state/counters/checksum update on the handshake edge.
// Backpressure: byt_rdy_i=0 holds byt_dat_o and all state; an empty FIFO drops byt_val_o and holds state.
//
// Ports:
//   clk, rstn             clock; synchronous active-high reset
//   cfg_w_i, cfg_h_i      image width (pixels) / height (rows), both >= 1
//   start_i / done_o      start pulse (IDLE only) / pulse on the final byte handshake
//   fifo_flt_*            show-ahead FIFO: empty flag, head word, pop strobe
//   byt_val_o/_dat_o/_rdy_i  byte stream with valid/ready handshake
//   adler_o               running Adler-32 {b, a}
// Build option: define FLT_PACK_ADLER_EN to include the checksum and its 4-byte trailer.

`ifndef SIZE_W_WD
`define SIZE_W_WD 16
`endif
`ifndef SIZE_H_WD
`define SIZE_H_WD 16
`endif
`ifndef DATA_PXL_WD
`define DATA_PXL_WD 32
`endif

module flt_pack (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [`SIZE_W_WD-1:0]   cfg_w_i,
  input  logic [`SIZE_H_WD-1:0]   cfg_h_i,
  input  logic                    start_i,
  output logic                    done_o,
  input  logic                    fifo_flt_empty_i,
  input  logic [`DATA_PXL_WD-1:0] fifo_flt_rd_dat_i,
  output logic                    fifo_flt_rd_val_o,
  output logic                    byt_val_o,
  output logic [7:0]              byt_dat_o,
  input  logic                    byt_rdy_i,
  output logic [31:0]             adler_o
);

  localparam int WW = `SIZE_W_WD;
  localparam int HW = `SIZE_H_WD;

  typedef enum logic [1:0] {IDLE, TYP, PXL, ADL} state_t;

  state_t          r_state;
  logic [WW-1:0]   r_cnt_w;
  logic [HW-1:0]   r_cnt_h;
  logic [1:0]      r_cnt_b;

  logic            w_byt_val;
  logic [7:0]      w_byt_dat;
  logic            w_hs;
  logic            w_last_b;
  logic            w_last_px;
  logic            w_last_row;
  logic [31:0]     w_adler;

`ifdef FLT_PACK_ADLER_EN
  logic [15:0]     r_adl_a;
  logic [15:0]     r_adl_b;
  logic [16:0]     w_a_sum;
  logic [15:0]     w_a_nxt;
  logic [16:0]     w_b_sum;
  logic [15:0]     w_b_nxt;

  // Both running sums stay below 65521, so one byte (or one a') can overshoot
  // the modulus at most once; a single conditional subtract is enough. The
  // subtraction is done on the low 16 bits: modulo 2^16 it gives the same result.
  assign w_a_sum = {1'b0, r_adl_a} + {9'd0, w_byt_dat};
  assign w_a_nxt = (w_a_sum >= 17'd65521) ? (w_a_sum[15:0] - 16'd65521) : w_a_sum[15:0];
  assign w_b_sum = {1'b0, r_adl_b} + {1'b0, w_a_nxt};
  assign w_b_nxt = (w_b_sum >= 17'd65521) ? (w_b_sum[15:0] - 16'd65521) : w_b_sum[15:0];
  assign w_adler = {r_adl_b, r_adl_a};
`else
  assign w_adler = 32'h0000_0001;
`endif

  assign w_last_b   = (r_cnt_b == 2'd3);
  assign w_last_px  = (r_cnt_w == cfg_w_i - WW'(1));
  assign w_last_row = (r_cnt_h == cfg_h_i - HW'(1));

  // Byte source mux. Kept combinational so byt_val_o tracks the show-ahead
  // empty flag in the same cycle; reset forces everything quiet immediately.
  always_comb begin
    w_byt_val = 1'b0;
    w_byt_dat = 8'h00;
    case (r_state)
      TYP: begin
        w_byt_val = !fifo_flt_empty_i;
        w_byt_dat = fifo_flt_rd_dat_i[31:24];
      end
      PXL: begin
        w_byt_val = !fifo_flt_empty_i;
        w_byt_dat = fifo_flt_rd_dat_i[{r_cnt_b, 3'b000} +: 8];
      end
`ifdef FLT_PACK_ADLER_EN
      ADL: begin
        w_byt_val = 1'b1;
        case (r_cnt_b)
          2'd0:    w_byt_dat = w_adler[31:24];
          2'd1:    w_byt_dat = w_adler[23:16];
          2'd2:    w_byt_dat = w_adler[15:8];
          default: w_byt_dat = w_adler[7:0];
        endcase
      end
`endif
      default: ;
    endcase
    if (rstn) begin
      w_byt_val = 1'b0;
      w_byt_dat = 8'h00;
    end
  end

  assign w_hs = w_byt_val && byt_rdy_i;

  // Pop only on the handshake that consumes the last byte of the head word;
  // w_byt_val already implies the FIFO is not empty in TYP/PXL.
  assign fifo_flt_rd_val_o = w_hs && ((r_state == TYP) || ((r_state == PXL) && w_last_b));

`ifdef FLT_PACK_ADLER_EN
  assign done_o = w_hs && (r_state == ADL) && w_last_b;
`else
  assign done_o = w_hs && (r_state == PXL) && w_last_b && w_last_px && w_last_row;
`endif

  assign byt_val_o = w_byt_val;
  assign byt_dat_o = w_byt_dat;
  assign adler_o   = w_adler;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= IDLE;
      r_cnt_w <= '0;
      r_cnt_h <= '0;
      r_cnt_b <= '0;
`ifdef FLT_PACK_ADLER_EN
      r_adl_a <= 16'd1;
      r_adl_b <= 16'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= TYP;
            r_cnt_w <= '0;
            r_cnt_h <= '0;
            r_cnt_b <= '0;
`ifdef FLT_PACK_ADLER_EN
            r_adl_a <= 16'd1;
            r_adl_b <= 16'd0;
`endif
          end
        end
        TYP: begin
          if (w_hs) begin
            r_state <= PXL;
            r_cnt_w <= '0;
            r_cnt_b <= '0;
`ifdef FLT_PACK_ADLER_EN
            r_adl_a <= w_a_nxt;
            r_adl_b <= w_b_nxt;
`endif
          end
        end
        PXL: begin
          if (w_hs) begin
`ifdef FLT_PACK_ADLER_EN
            r_adl_a <= w_a_nxt;
            r_adl_b <= w_b_nxt;
`endif
            if (w_last_b) begin
              r_cnt_b <= '0;
              if (w_last_px) begin
                r_cnt_w <= '0;
                if (w_last_row) begin
                  r_cnt_h <= '0;
`ifdef FLT_PACK_ADLER_EN
                  r_state <= ADL;
`else
                  r_state <= IDLE;
`endif
                end else begin
                  r_cnt_h <= r_cnt_h + HW'(1);
                  r_state <= TYP;
                end
              end else begin
                r_cnt_w <= r_cnt_w + WW'(1);
              end
            end else begin
              r_cnt_b <= r_cnt_b + 2'd1;
            end
          end
        end
`ifdef FLT_PACK_ADLER_EN
        ADL: begin
          if (w_hs) begin
            if (w_last_b) begin
              r_cnt_b <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt_b <= r_cnt_b + 2'd1;
            end
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/flt_pack.md
FLT_PACK -- requirements
Module: flt_pack

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rstn  input  1  reset, synchronous and active-high: asserted when 1, sampled on the clk rising edge.
REQ-003 cfg_w_i  input  `SIZE_W_WD  image width in pixels; 1 or more; stable from start_i until done_o.
REQ-004 cfg_h_i  input  `SIZE_H_WD  image height in scanlines; 1 or more; stable from start_i until done_o.
REQ-005 start_i  input  1  one-cycle pulse that starts one image; ignored unless in IDLE.
REQ-006 done_o  output  1  one-cycle pulse when the last byte of the image is accepted.
REQ-007 fifo_flt_empty_i  input  1  filtered-data FIFO empty flag.
REQ-008 fifo_flt_rd_dat_i  input  `DATA_PXL_WD  FIFO head word (show-ahead: valid whenever not empty).
REQ-009 fifo_flt_rd_val_o  output  1  pop strobe; pops the head word this cycle.
REQ-010 byt_val_o  output  1  output byte valid.
REQ-011 byt_dat_o  output  8  output byte.
REQ-012 byt_rdy_i  input  1  downstream ready; a byte transfers when byt_val_o and byt_rdy_i are both 1 ("handshake").
REQ-013 adler_o  output  32  running Adler-32 value {b[15:0], a[15:0]}.

Function
REQ-014 Input stream per scanline: one type word (type in [31:24]), then cfg_w_i pixel words; the block SHALL serialize it into a zlib-payload byte stream.
REQ-015 FSM states: IDLE, TYP, PXL, ADL.
- IDLE to TYP on start_i.
- TYP to PXL after the type-byte handshake.
- PXL to TYP at the end of the last pixel of a row when that row is not the last.
- PXL to ADL at the end of the last pixel of the last row.
- ADL to IDLE after the 4th checksum byte.
REQ-016 TYP: byt_val_o = !fifo_flt_empty_i; byt_dat_o = head[31:24]; on handshake pop the word, and clear cnt_w and cnt_b.
REQ-017 PXL: byt_val_o = !fifo_flt_empty_i; byt_dat_o = head[8*cnt_b +: 8], so channel 0 (bits [7:0]) goes first.
- Each handshake increments cnt_b.
- The handshake with cnt_b==3 pops the word, sets cnt_b to 0 and increments cnt_w.
- At cnt_w==cfg_w_i-1 it instead clears cnt_w and increments cnt_h, or ends the image.
REQ-018 fifo_flt_rd_val_o SHALL be asserted only in the handshake cycle that consumes the last byte of the head word; the block never pops an empty FIFO.
REQ-019 ADL: byt_val_o = 1; bytes are adler_o[31:24], [23:16], [15:8], [7:0] in that order (big-endian), indexed by cnt_b.
REQ-020 Adler-32 update on every handshake in TYP or PXL:
- a' = a + byte, minus 65521 if the sum is 65521 or more.
- b' = b + a', minus 65521 if the sum is 65521 or more.
- One conditional subtract is sufficient for both.
REQ-021 a is set to 1 and b to 0 on start_i; ADL bytes do not update the checksum.
REQ-022 byt_dat_o SHALL stay stable while byt_val_o=1 and byt_rdy_i=0; the FIFO is not popped in that case.
REQ-023 FIFO empty mid-row: byt_val_o=0 and state/counters hold; no bytes are lost or duplicated.
REQ-024 Bytes per image: cfg_h_i*(1+4*cfg_w_i), plus 4 in ADL.
REQ-025 done_o SHALL pulse in the cycle of the final handshake; the FSM is in IDLE on the next cycle.
REQ-026 start_i coinciding with done_o SHALL be ignored.

Reset
REQ-027 While rstn=1:
- state goes to IDLE;
- cnt_w, cnt_h and cnt_b go to 0;
- adler_o = 32'h0000_0001;
- byt_val_o, byt_dat_o, done_o and fifo_flt_rd_val_o go to 0.
REQ-028 Reset mid-image SHALL abort the image immediately: no further pops, no done_o pulse; the next start_i begins a fresh image.

Configuration
REQ-029 Macro FLT_PACK_ADLER_EN defined: Adler logic and the ADL state are present, per REQ-019..021.
REQ-030 Macro FLT_PACK_ADLER_EN undefined:
- no checksum logic;
- adler_o tied to 32'h0000_0001;
- PXL goes directly to IDLE after the last pixel byte, and done_o pulses on that handshake.

Verification
REQ-031 Basic image (byt_rdy_i=1): w=1, h=1, words 0x01000000 then 0x04030201.
- Bytes: 01 01 02 03 04 00 1E 00 0C.
- adler_o=0x001E000C; done_o pulses once on the 9th byte.
REQ-032 Backpressure: same stimulus with byt_rdy_i toggling 1/0 every cycle.
- Identical byte sequence; byt_dat_o stable while stalled; exactly 2 pops.
REQ-033 Modulo wrap: w=65, h=1, type 0, all pixels 0xFFFFFFFF.
- 261 data bytes followed by 0E 37 03 0C (a=780, b=3639).
REQ-034 FIFO underflow: w=2, h=2, empty_i held 1 for 10 cycles between words.
- No spurious byt_val_o; 18+4 bytes total; rd_val_o never asserted while empty.
REQ-035 Reset abort: assert rstn for 1 cycle after byte 3 of REQ-031.
- All outputs take reset values; no done_o.
- A following start_i with fresh data reproduces REQ-031 exactly.
REQ-036 Macro off: REQ-031 stimulus gives 5 bytes only; done_o on byte 5; adler_o=1.
